mult_station: RTL
=================

Name: mult_station

Overview:
- Multiply reservation station plus a single iterative multiply unit.
- Entries are tagged M0 (8'h30) and M1 (8'h31).
- Accepts dispatched MULTI operations with operand {tag,value} pairs and snoops loadbus, addbus and its own multbus for pending operands.
- Broadcasts each 32-bit result on multbus as {tag[39:32], data[31:0]}; this is the producer end of the multbus the register file consumes.

Parameters:
- MUL_LAT, 3, cycles from operation start edge to multbus broadcast edge (range 1..15).
- TAG_M0, 8'h30, tag of entry 0.
- TAG_M1, 8'h31, tag of entry 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- iss_valid  input  1  issue strobe, sampled at rising edge.
- iss_tag  input  8  target entry tag; only TAG_M0 or TAG_M1 is legal.
- iss_src1  input  40  {tag, value}; tag 8'h00 means the value is ready.
- iss_src2  input  40  same encoding as iss_src1.
- loadbus  input  40  load result broadcast {tag, data}; tag 8'h00 means idle.
- addbus  input  40  add result broadcast, same encoding.
- multbus  output  40  registered result broadcast {tag, product}; all-zero when idle.
- m0_busy  output  1  entry M0 occupied.
- m1_busy  output  1  entry M1 occupied.
- iss_rej  output  1  one-cycle pulse when an issue is refused.

Behaviour:
- Reset (sync, active-high) clears everything: multbus=40'h0, m0_busy=0, m1_busy=0, iss_rej=0, both entries invalid, unit IDLE, age bit=0. Reset mid-operation aborts with no broadcast.
- Each entry holds: busy, q1/v1, q2/v2 (8-bit tag, 32-bit value), and a started flag.
- Issue:
  - Accepted at edge E0 when iss_valid=1, iss_tag is TAG_M0 or TAG_M1, and that entry is not busy. The entry is busy from E0 onward.
  - Refused otherwise: illegal tag, or entry busy. A refusal pulses iss_rej for the cycle after E0, and the entry is unchanged.
- Issue-cycle forwarding: if a source tag is nonzero and equals the tag on loadbus, addbus or multbus in that same cycle, the bus data is captured and q is set to 0.
- Snooping: every edge, each busy entry with q!=0 compares q against all three bus tags. On a match it latches the data and clears q. Bus tag 8'h00 never matches.
- Operand ready: an entry is ready when q1==0, q2==0 and started==0.
- Unit FSM:
  - IDLE: at any edge with at least one ready entry, latch v1 and v2, set started, load counter=MUL_LAT-1, and go to BUSY.
  - Selection when both entries are ready: the older issue wins; on an age tie (same-edge state impossible) M0 wins.
  - BUSY: decrement the counter each edge. At the edge where the counter is 0, drive multbus={tag, result} for exactly one cycle, clear that entry's busy and started, and return to IDLE.
  - The next start is at the following edge at the earliest.
- Timing: an issue with ready operands at edge E0 starts at E0+1 and broadcasts after E0+1+MUL_LAT. With MUL_LAT=3, multbus is valid in the cycle after edge 4.
- Slot reuse: a new issue to a freed tag is accepted at the edge after its broadcast edge.
- Self-forwarding: an entry waiting on the other entry's tag captures multbus during the broadcast cycle and starts at the following edge.
- Arithmetic: unsigned 32x32 multiply; the result is the low 32 bits, subject to the optional feature below.
- multbus returns to 40'h0 in the cycle after a broadcast.

Optional Feature:
- Macro: MULT_SAT_EN.
- Defined: if product[63:32]!=0, the result is 32'hFFFFFFFF; otherwise it is product[31:0].
- Undefined: the result is product[31:0] (truncation, no saturation logic).

Test Plan:
- Basic issue: reset; issue M0 with src1={00,32'h3}, src2={00,32'h7} at edge 1 -> multbus={8'h30,32'h15} in the cycle after edge 5 only; m0_busy falls with it.
- Operand wait:
  - Issue M1 with src1={8'h40,x}, src2={00,32'h2}.
  - loadbus={8'h40,32'habcede23} two cycles later.
  - Required: start at the next edge; multbus={8'h31,32'h579bbc46}, i.e. the low 32 bits of 32'habcede23 x 2; the saturated value 32'hFFFFFFFF when MULT_SAT_EN is defined.
- Contention:
  - Issue M1 ready, then M0 ready one cycle later while the unit is busy.
  - Required: M1 broadcasts first; M0 starts at the edge after M1's broadcast and broadcasts MUL_LAT edges later.
- Self-forward:
  - Issue M0 with src1={8'h21,...} (add pending) and src2={8'h31,...}; M1 computes 32'h10.
  - Required: M0 captures 32'h10 from multbus.
  - addbus then supplies {8'h21,32'h5}; M0 result=32'h50.
- Refusal: issue to busy M0, and issue with iss_tag=8'h20 -> iss_rej pulses for one cycle each; M0 contents are unchanged.
- Same-cycle forward and reset: issue src1 tag 8'h20 while addbus={8'h20,32'h9} -> the operand is captured immediately. Assert rst mid-BUSY -> no broadcast, busy flags 0.

Source files
------------

// File: rtl/mult_station.sv
// ---------------------------------------------------------------------------
// mult_station -- two-entry multiply reservation station (tags M0/M1) feeding
// a single multi-cycle multiply unit that broadcasts on multbus.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   iss_valid  issue strobe
//   iss_tag    target entry tag (TAG_M0 / TAG_M1; anything else is refused)
//   iss_src1/2 {tag, value} operands; tag 8'h00 means the value is ready
//   loadbus    load result broadcast {tag, data}; tag 8'h00 = idle
//   addbus     add result broadcast {tag, data}; tag 8'h00 = idle
//   multbus    registered result broadcast {tag, product}; 0 when idle
//   m0_busy    entry M0 occupied
//   m1_busy    entry M1 occupied
//   iss_rej    one-cycle pulse after a refused issue
//
// Build option
//   MULT_SAT_EN  when defined, a product that overflows 32 bits is reported
//                as 32'hFFFFFFFF; otherwise the low 32 bits are reported.
// ---------------------------------------------------------------------------
module mult_station #(
   parameter int unsigned MUL_LAT = 3,
   parameter logic [7:0]  TAG_M0  = 8'h30,
   parameter logic [7:0]  TAG_M1  = 8'h31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iss_valid,
   input  logic [7:0]  iss_tag,
   input  logic [39:0] iss_src1,
   input  logic [39:0] iss_src2,
   input  logic [39:0] loadbus,
   input  logic [39:0] addbus,
   output logic [39:0] multbus,
   output logic        m0_busy,
   output logic        m1_busy,
   output logic        iss_rej
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t           state_q, state_d;
   logic [1:0]       busy_q, busy_d;
   logic [1:0]       started_q, started_d;
   logic [1:0][39:0] src1_q, src1_d;    // {q, v} per entry
   logic [1:0][39:0] src2_q, src2_d;
   logic             old_q, old_d;      // index of the older entry
   logic             sel_q, sel_d;      // entry owned by the unit
   logic [3:0]       cnt_q, cnt_d;
   logic [31:0]      op1_q, op1_d, op2_q, op2_d;
   logic [39:0]      mb_q, mb_d;
   logic             rej_q, rej_d;

   logic [1:0]       ready;
   logic             pick;
   logic             iss_idx;
   logic             iss_legal;
   logic [31:0]      result;

   // Resolve a pending operand against the three result buses. A tag of 0
   // is already resolved, so an idle bus (tag 0) can never match.
   function automatic logic [39:0] snoop(input logic [39:0] opnd,
                                         input logic [39:0] lb,
                                         input logic [39:0] ab,
                                         input logic [39:0] mb);
      logic [7:0] q;
      q = opnd[39:32];
      if (q == 8'h00)        return opnd;
      if (lb[39:32] == q)    return {8'h00, lb[31:0]};
      if (ab[39:32] == q)    return {8'h00, ab[31:0]};
      if (mb[39:32] == q)    return {8'h00, mb[31:0]};
      return opnd;
   endfunction

`ifdef MULT_SAT_EN
   logic [63:0] prod;
   assign prod   = {32'h0, op1_q} * {32'h0, op2_q};
   assign result = (prod[63:32] != 32'h0) ? 32'hFFFF_FFFF : prod[31:0];
`else
   assign result = op1_q * op2_q;
`endif

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         ready[i] = busy_q[i] & ~started_q[i] &
                    (src1_q[i][39:32] == 8'h00) & (src2_q[i][39:32] == 8'h00);
      end
   end

   // Both ready: the older one wins (age bit resets to M0).
   assign pick      = (ready[0] & ready[1]) ? old_q : ready[1];
   assign iss_idx   = (iss_tag == TAG_M1);
   assign iss_legal = (iss_tag == TAG_M0) || (iss_tag == TAG_M1);

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      started_d = started_q;
      src1_d    = src1_q;
      src2_d    = src2_q;
      old_d     = old_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      mb_d      = '0;
      rej_d     = 1'b0;

      for (int i = 0; i < 2; i++) begin
         if (busy_q[i]) begin
            src1_d[i] = snoop(src1_q[i], loadbus, addbus, mb_q);
            src2_d[i] = snoop(src2_q[i], loadbus, addbus, mb_q);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (|ready) begin
               sel_d            = pick;
               op1_d            = src1_q[pick][31:0];
               op2_d            = src2_q[pick][31:0];
               started_d[pick]  = 1'b1;
               cnt_d            = 4'(MUL_LAT - 1);
               state_d          = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q == 4'd0) begin
               mb_d              = {(sel_q ? TAG_M1 : TAG_M0), result};
               busy_d[sel_q]     = 1'b0;
               started_d[sel_q]  = 1'b0;
               state_d           = S_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A busy target is never the one freed this edge, so the issue write
      // never collides with the broadcast clear above.
      if (iss_valid) begin
         if (iss_legal && !busy_q[iss_idx]) begin
            busy_d[iss_idx]    = 1'b1;
            started_d[iss_idx] = 1'b0;
            src1_d[iss_idx]    = snoop(iss_src1, loadbus, addbus, mb_q);
            src2_d[iss_idx]    = snoop(iss_src2, loadbus, addbus, mb_q);
            old_d              = busy_q[~iss_idx] ? ~iss_idx : iss_idx;
         end else begin
            rej_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         busy_q    <= '0;
         started_q <= '0;
         src1_q    <= '0;
         src2_q    <= '0;
         old_q     <= 1'b0;
         sel_q     <= 1'b0;
         cnt_q     <= '0;
         op1_q     <= '0;
         op2_q     <= '0;
         mb_q      <= '0;
         rej_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         started_q <= started_d;
         src1_q    <= src1_d;
         src2_q    <= src2_d;
         old_q     <= old_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         mb_q      <= mb_d;
         rej_q     <= rej_d;
      end
   end

   assign multbus = mb_q;
   assign m0_busy = busy_q[0];
   assign m1_busy = busy_q[1];
   assign iss_rej = rej_q;

endmodule
